// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory controller.
// Holds the controller FSM encoding and the read-latency counter sizing.
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam int RD_LAT_MAX = 8;
  localparam int LAT_CNT_W  = 3;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage with one byte-enabled write port and one
// asynchronous read port; contents have no reset.
module data_mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready request port, byte-lane writes,
// configurable read latency, clear-after-reset sequencing and range checking.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 64,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int                    BE_W     = DATA_W / 8;
  localparam logic [ADDR_W-1:0]     LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]       DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [LAT_CNT_W-1:0]  LAT_INIT = LAT_CNT_W'(RD_LAT - 1);
  localparam logic [LAT_CNT_W-1:0]  LAT_LAST = LAT_CNT_W'(1);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      clr_idx;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic                   rd_err_q;
  logic                   in_range;
  logic                   accept;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [BE_W-1:0]        mem_wbe;
  logic [ADDR_W-1:0]      mem_raddr;
  logic [DATA_W-1:0]      mem_rdata;
  logic [DATA_W-1:0]      merged;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester must hold req_* stable while req_valid is high and req_ready is low.
  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_V;

  // During BUSY the captured address drives the read port so a held request cannot disturb it.
  assign mem_raddr = (state == ST_BUSY) ? rd_addr_q : req_addr;

  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (req_be[i]) merged[i*8 +: 8] = req_wdata[i*8 +: 8];
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wbe   (mem_wbe),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (CLEAR_ON_RESET == 0 || clr_idx == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE:  if (accept && !req_we && RD_LAT > 1) state_nxt = ST_BUSY;
      ST_BUSY:  if (lat_cnt == LAT_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Single write mux: the clear sequencer owns the port in CLEAR, requests in IDLE.
  always_comb begin
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = req_wdata;
    mem_wbe   = req_be;
    case (state)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx;
          mem_wdata = '0;
          mem_wbe   = '1;
        end
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        mem_we    = req_valid && req_we && in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx   <= '0;
      lat_cnt   <= '0;
      init_done <= 1'b0;
      rd_addr_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (state_nxt == ST_IDLE) init_done <= 1'b1;
      end
      if (accept && !req_we) begin
        rd_addr_q <= req_addr;
        rd_err_q  <= !in_range;
        lat_cnt   <= LAT_INIT;
      end else if (state == ST_BUSY) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  // Out-of-range accesses report 0 data; response fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept && (req_we || RD_LAT == 1)) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !in_range;
        rsp_rdata <= !in_range ? '0 : (req_we ? merged : mem_rdata);
      end else if (state == ST_BUSY && lat_cnt == LAT_LAST) begin
        rsp_valid <= 1'b1;
        rsp_err   <= rd_err_q;
        rsp_rdata <= rd_err_q ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (defaults, DEPTH=48, RD_LAT=3)
// sharing one clock, with a cycle-stamped response scoreboard.
module tb_data_mem_ctrl;

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] cyc;
    logic        chk;
    logic        err;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    bit          we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_d;
  } vec_t;

  logic        clk;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [5:0]  req_addr  [3];
  logic [15:0] req_wdata [3];
  logic [1:0]  req_be    [3];
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        init_done [3];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [15:0] model [64];
  vec_t tbl [15];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl u_def (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .init_done(init_done[0])
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_d48 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .init_done(init_done[1])
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_lat3 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .init_done(init_done[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_init(input int k, input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!init_done[k] && n < 300);
    check($sformatf("init_cycles_%0d", k), n, exp_n);
  endtask

  task automatic rst_pulse(input int k, input int n, input int exp_n);
    @(negedge clk);
    rst[k] = 1'b1;
    req_valid[k] = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_ready", {31'd0, req_ready[k]}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid[k]}, 0);
    check("rst_rdata", {16'd0, rsp_rdata[k]}, 0);
    check("rst_err", {31'd0, rsp_err[k]}, 0);
    check("rst_init_done", {31'd0, init_done[k]}, 0);
    rst[k] = 1'b0;
    wait_init(k, exp_n);
  endtask

  task automatic issue(input int k, input bit we, input logic [5:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be,
                       input logic [15:0] exp_d, input bit exp_e, input bit chk_d,
                       input int lat, input bit push);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    while (!req_ready[k] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    if (push) begin
      e.inst = 2'(k);
      e.cyc  = 32'(cyc + lat);
      e.chk  = chk_d;
      e.err  = exp_e;
      e.data = exp_d;
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic release_req(input int k);
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_rsp_%0d", k), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_inst", k, {30'd0, e.inst});
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_err", {31'd0, rsp_err[k]}, {31'd0, e.err});
          if (e.chk) check("rsp_data", {16'd0, rsp_rdata[k]}, {16'd0, e.data});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
    end
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;

    tbl[0]  = '{1'b0, 6'd5, 16'h0000, 2'b00, 16'h0000};
    tbl[1]  = '{1'b1, 6'd3, 16'hBEEF, 2'b11, 16'hBEEF};
    tbl[2]  = '{1'b0, 6'd3, 16'h0000, 2'b00, 16'hBEEF};
    tbl[3]  = '{1'b1, 6'd3, 16'h1234, 2'b01, 16'hBE34};
    tbl[4]  = '{1'b0, 6'd3, 16'h0000, 2'b00, 16'hBE34};
    tbl[5]  = '{1'b1, 6'd0, 16'h000A, 2'b11, 16'h000A};
    tbl[6]  = '{1'b1, 6'd1, 16'h000B, 2'b11, 16'h000B};
    tbl[7]  = '{1'b1, 6'd2, 16'h000C, 2'b11, 16'h000C};
    tbl[8]  = '{1'b0, 6'd0, 16'h0000, 2'b00, 16'h000A};
    tbl[9]  = '{1'b0, 6'd1, 16'h0000, 2'b00, 16'h000B};
    tbl[10] = '{1'b0, 6'd2, 16'h0000, 2'b00, 16'h000C};
    tbl[11] = '{1'b1, 6'd4, 16'hFFFF, 2'b00, 16'h0000};
    tbl[12] = '{1'b0, 6'd4, 16'h0000, 2'b00, 16'h0000};
    tbl[13] = '{1'b1, 6'd3, 16'hABCD, 2'b10, 16'hAB34};
    tbl[14] = '{1'b0, 6'd3, 16'h0000, 2'b00, 16'hAB34};

    // Default instance: clear timing, then random traffic on the upper half.
    rst_pulse(0, 2, 64);
    for (int i = 0; i < 24; i++) begin
      logic [5:0]  a;
      logic [15:0] d, m;
      logic [1:0]  be;
      bit          we;
      a  = 6'(32 + $urandom_range(0, 31));
      d  = 16'($urandom_range(0, 65535));
      be = 2'($urandom_range(0, 3));
      we = bit'($urandom_range(0, 1));
      m  = model[a];
      if (we) begin
        if (be[0]) m[7:0]  = d[7:0];
        if (be[1]) m[15:8] = d[15:8];
        model[a] = m;
      end
      issue(0, we, a, d, be, m, 1'b0, 1'b1, 1, 1'b1);
    end

    // Table vectors, issued back to back on the lower addresses.
    for (int i = 0; i < 15; i++)
      issue(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_d, 1'b0, 1'b1, 1, 1'b1);
    release_req(0);
    repeat (3) @(negedge clk);
    check("rdata_hold", {16'd0, rsp_rdata[0]}, 32'hAB34);
    check("valid_idle", {31'd0, rsp_valid[0]}, 0);

    // DEPTH=48: out-of-range accesses must not alias onto addr 2.
    rst_pulse(1, 2, 48);
    issue(1, 1'b1, 6'd2,  16'h5A5A, 2'b11, 16'h5A5A, 1'b0, 1'b1, 1, 1'b1);
    issue(1, 1'b1, 6'd50, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 1'b0, 1, 1'b1);
    issue(1, 1'b0, 6'd50, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b1, 1, 1'b1);
    issue(1, 1'b0, 6'd2,  16'h0000, 2'b00, 16'h5A5A, 1'b0, 1'b1, 1, 1'b1);
    issue(1, 1'b0, 6'd47, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b1, 1, 1'b1);
    release_req(1);

    // RD_LAT=3: latency, BUSY back-pressure, then reset during a pending read.
    rst_pulse(2, 2, 64);
    issue(2, 1'b1, 6'd7, 16'h7777, 2'b11, 16'h7777, 1'b0, 1'b1, 1, 1'b1);
    issue(2, 1'b0, 6'd7, 16'h0000, 2'b00, 16'h7777, 1'b0, 1'b1, 3, 1'b1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("busy_ready", {31'd0, req_ready[2]}, 0);
    repeat (4) @(negedge clk);
    issue(2, 1'b0, 6'd7, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0, 3, 1'b0);
    rst_pulse(2, 1, 64);
    issue(2, 1'b0, 6'd7, 16'h0000, 2'b00, 16'h0000, 1'b0, 1'b1, 3, 1'b1);
    release_req(2);

    repeat (10) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
